// File: rtl/alu_pkg.sv
// Shared definitions for the ALU-side shift path: widths, FSM encoding and
// the stage index the sequenced shifter starts from.
package alu_pkg;

  localparam int WIDTH   = 32;
  localparam int SHAMT_W = 5;

  localparam logic [2:0] STAGE_TOP = 3'd4;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    DONE  = 2'b10
  } state_t;

endpackage

// File: rtl/right_shift_stage.sv
// One power-of-two stage of the right shifter: shifts by 2^stage when enabled,
// filling vacated MSBs with the sign bit for arithmetic shifts.
module right_shift_stage
  import alu_pkg::*;
(
  input  logic [WIDTH-1:0] value,
  input  logic [2:0]       stage,
  input  logic             enable,
  input  logic             arith,
  output logic [WIDTH-1:0] shifted
);

  logic [5:0]       amount;
  logic [WIDTH-1:0] srl_value;
  logic [WIDTH-1:0] sra_value;

  always_comb begin
    amount    = 6'd1 << stage;
    srl_value = value >> amount;
    sra_value = $signed(value) >>> amount;
    shifted   = value;
    if (enable) begin
      shifted = arith ? sra_value : srl_value;
    end
  end

endmodule

// File: rtl/seq_right_shifter.sv
// Multi-cycle 32-bit SRL/SRA: one barrel stage per clock (16, 8, 4, 2, 1),
// fixed 5-cycle latency, valid/ready on both operand and result sides.
module seq_right_shifter
  import alu_pkg::*;
(
  input  logic               clock,
  input  logic               reset_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  input  logic               arith,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   result
);

  state_t             state, state_next;
  logic [2:0]         stage;
  logic [WIDTH-1:0]   data;
  logic [SHAMT_W-1:0] shamt_q;
  logic               arith_q;
  logic               stage_en;
  logic [WIDTH-1:0]   stage_out;

  // Sign stays in data[31] across stages, so the single stage reuses it directly.
  assign stage_en = |(shamt_q & (SHAMT_W'(1) << stage));

  right_shift_stage u_stage (
    .value   (data),
    .stage   (stage),
    .enable  (stage_en),
    .arith   (arith_q),
    .shifted (stage_out)
  );

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = SHIFT;
      end
      SHIFT: begin
        if (stage == 3'd0) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stage   <= 3'd0;
      data    <= '0;
      shamt_q <= '0;
      arith_q <= 1'b0;
      result  <= '0;
    end else begin
      if (state == IDLE && in_valid) begin
        data    <= data_in;
        shamt_q <= shamt;
        arith_q <= arith;
        stage   <= STAGE_TOP;
      end else if (state == SHIFT) begin
        data <= stage_out;
        if (stage == 3'd0) begin
          result <= stage_out;
        end else begin
          stage <= stage - 3'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_seq_right_shifter.sv
// Directed bench for seq_right_shifter: latency, SRL/SRA fill, backpressure,
// mid-operation reset, and a short randomised run against a behavioural model.
module tb_seq_right_shifter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] data_in;
  logic [4:0]  shamt;
  logic        arith;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] result;

  int tests = 0;
  int fails = 0;

  seq_right_shifter dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .data_in   (data_in),
    .shamt     (shamt),
    .arith     (arith),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result)
  );

  always #5 clock = ~clock;

  // Inputs change and outputs are sampled on the falling edge.
  task automatic tick();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Presents one operand for exactly one edge (the accept edge).
  task automatic applyStimulus(input logic [31:0] d, input logic [4:0] s, input logic a);
    in_valid = 1'b1;
    data_in  = d;
    shamt    = s;
    arith    = a;
    tick();
    in_valid = 1'b0;
  endtask

  // Walks the five SHIFT cycles and lands in DONE without handing off.
  task automatic waitResult(input string tag, input logic [31:0] exp);
    for (int k = 1; k <= 4; k++) begin
      tick();
      if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
        checkOutput({tag, "_busy_flags"}, {30'd0, out_valid, in_ready}, 32'd0);
      end
    end
    tick();
    checkOutput({tag, "_out_valid"}, {31'd0, out_valid}, 32'd1);
    checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    checkOutput({tag, "_result"}, result, exp);
  endtask

  task automatic handoff(input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd1);
    checkOutput({tag, "_valid_drop"}, {31'd0, out_valid}, 32'd0);
  endtask

  function automatic logic [31:0] model(input logic [31:0] d, input logic [4:0] s, input logic a);
    logic [31:0] r;
    r = d >> s;
    if (a && d[31]) r = r | ~(32'hFFFF_FFFF >> s);
    return r;
  endfunction

  initial begin
    logic [31:0] rd;
    logic [4:0]  rs;
    logic        ra;
    logic [31:0] held;
    int          stall;

    reset_n   = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    shamt     = '0;
    arith     = 1'b0;
    out_ready = 1'b0;
    tick();
    tick();
    reset_n = 1'b1;
    checkOutput("reset_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("reset_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("reset_result", result, 32'd0);

    applyStimulus(32'h8000_0000, 5'd4, 1'b0);
    checkOutput("srl4_in_ready_after_accept", {31'd0, in_ready}, 32'd0);
    waitResult("srl4", 32'h0800_0000);
    handoff("srl4");

    applyStimulus(32'h8000_0000, 5'd31, 1'b1);
    waitResult("sra31_neg", 32'hFFFF_FFFF);
    handoff("sra31_neg");

    applyStimulus(32'h8000_0000, 5'd31, 1'b0);
    waitResult("srl31", 32'h0000_0001);
    handoff("srl31");

    applyStimulus(32'hF0F0_F0F0, 5'd8, 1'b1);
    waitResult("sra8", 32'hFFF0_F0F0);
    handoff("sra8");

    applyStimulus(32'h1234_5678, 5'd0, 1'b1);
    waitResult("zero_shift", 32'h1234_5678);
    handoff("zero_shift");

    applyStimulus(32'h7FFF_FFFF, 5'd31, 1'b1);
    waitResult("sra31_pos", 32'h0000_0000);
    handoff("sra31_pos");

    applyStimulus(32'hFFFF_FFFF, 5'd1, 1'b0);
    waitResult("srl1", 32'h7FFF_FFFF);
    handoff("srl1");

    // Backpressure: DONE held while a new operand is waiting.
    applyStimulus(32'h8000_0000, 5'd4, 1'b0);
    waitResult("bp", 32'h0800_0000);
    in_valid = 1'b1;
    data_in  = 32'hDEAD_BEEF;
    shamt    = 5'd4;
    arith    = 1'b0;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkOutput("bp_hold_valid", {31'd0, out_valid}, 32'd1);
      checkOutput("bp_hold_in_ready", {31'd0, in_ready}, 32'd0);
      checkOutput("bp_hold_result", result, 32'h0800_0000);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    checkOutput("bp_release_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("bp_release_valid", {31'd0, out_valid}, 32'd0);
    tick();
    in_valid = 1'b0;
    checkOutput("bp_accepted", {31'd0, in_ready}, 32'd0);
    waitResult("bp_next", 32'h0DEA_DBEE);
    handoff("bp_next");

    // Reset asserted during the third SHIFT cycle.
    applyStimulus(32'hFFFF_0000, 5'd3, 1'b1);
    tick();
    tick();
    reset_n = 1'b0;
    tick();
    reset_n = 1'b1;
    checkOutput("rst_mid_in_ready", {31'd0, in_ready}, 32'd1);
    checkOutput("rst_mid_out_valid", {31'd0, out_valid}, 32'd0);
    checkOutput("rst_mid_result", result, 32'd0);
    for (int k = 0; k < 8; k++) begin
      tick();
      checkOutput("rst_no_pulse", {31'd0, out_valid}, 32'd0);
    end

    // Randomised operands with random consumer stalls.
    for (int i = 0; i < 300; i++) begin
      rd = $urandom;
      rs = 5'($urandom_range(0, 31));
      ra = 1'($urandom_range(0, 1));
      applyStimulus(rd, rs, ra);
      waitResult("rand", model(rd, rs, ra));
      held  = result;
      stall = $urandom_range(0, 2);
      for (int k = 0; k < stall; k++) begin
        tick();
        checkOutput("rand_stall_result", result, held);
        checkOutput("rand_stall_valid", {31'd0, out_valid}, 32'd1);
      end
      handoff("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
